// File: rtl/i4004_timing_pkg.sv
// Shared encodings for the i4004 master timing generator.
// Holds the subcycle and phase enums and the subcycle strobe vector indices.
package i4004_timing_pkg;

  typedef enum logic [2:0] {
    SUB_A1 = 3'd0,
    SUB_A2 = 3'd1,
    SUB_A3 = 3'd2,
    SUB_M1 = 3'd3,
    SUB_M2 = 3'd4,
    SUB_X1 = 3'd5,
    SUB_X2 = 3'd6,
    SUB_X3 = 3'd7
  } sub_e;

  typedef enum logic [1:0] {
    PH_CLK1 = 2'd0,
    PH_GAP1 = 2'd1,
    PH_CLK2 = 2'd2,
    PH_GAP2 = 2'd3
  } ph_e;

  localparam int STB_W   = 8;
  localparam int STB_A12 = 0;
  localparam int STB_A22 = 1;
  localparam int STB_A32 = 2;
  localparam int STB_M12 = 3;
  localparam int STB_M22 = 4;
  localparam int STB_X12 = 5;
  localparam int STB_X22 = 6;
  localparam int STB_X32 = 7;

endpackage

// File: rtl/timing_gen_if.sv
// Timing bundle from timing_gen to the scratchpad, ALU and decode boards.
// Ports: clk1/clk2 phase enables, k2 subcycle strobes, combined M-strobe, sync, poc.
interface timing_gen_if;
  logic clk1;
  logic clk2;
  logic a12;
  logic a22;
  logic a32;
  logic m12;
  logic m22;
  logic x12;
  logic x22;
  logic x32;
  logic m12_m22_clk1_m11_m12;
  logic sync;
  logic poc;

  modport master (
    output clk1, clk2,
    output a12, a22, a32,
    output m12, m22,
    output x12, x22, x32,
    output m12_m22_clk1_m11_m12,
    output sync, poc
  );

  modport slave (
    input clk1, clk2,
    input a12, a22, a32,
    input m12, m22,
    input x12, x22, x32,
    input m12_m22_clk1_m11_m12,
    input sync, poc
  );
endinterface

// File: rtl/timing_prescaler.sv
// Phase prescaler: counts PHASE_LEN sysclk cycles per phase.
// Ports: i_clk, i_rst_n (sync, active low), o_phase_step (high on last tick).
module timing_prescaler #(
  parameter int PHASE_LEN = 17
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_phase_step
);

  localparam int TW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam logic [TW-1:0] LAST = TW'(PHASE_LEN - 1);

  logic [TW-1:0] r_tick;

  // Reset parks on the last tick so the first released edge steps phase.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tick <= LAST;
    end else if (r_tick == LAST) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + TW'(1);
    end
  end

  assign o_phase_step = (r_tick == LAST);

endmodule

// File: rtl/timing_gen.sv
// i4004 master timing: two-phase clocks, A1..X3 subcycle strobes, sync, poc.
// Ports: sysclk, poc_n (sync active-low reset), o_tg (timing_gen_if master).
module timing_gen
  import i4004_timing_pkg::*;
#(
  parameter int PHASE_LEN  = 17,
  parameter int POC_CYCLES = 2
) (
  input logic          sysclk,
  input logic          poc_n,
  timing_gen_if.master o_tg
);

  localparam int PCW = (POC_CYCLES > 0) ? $clog2(POC_CYCLES + 1) : 1;
  localparam logic [PCW-1:0] POC_MAX = PCW'(POC_CYCLES);

  logic w_step;

  sub_e           r_sub;
  ph_e            r_ph;
  logic [PCW-1:0] r_pcnt;
  logic           r_armed;

  sub_e           w_sub_n;
  ph_e            w_ph_n;
  logic [PCW-1:0] w_pcnt_n;
  logic           w_armed_n;
  logic           w_wrap;

  logic [2:0]       w_idx;
  logic [STB_W-1:0] w_stb;
  logic             w_clk1;
  logic             w_clk2;
  logic             w_m11;
  logic             w_mc;
  logic             w_sync;
  logic             w_poc;

  logic [STB_W-1:0] r_stb;
  logic             r_clk1;
  logic             r_clk2;
  logic             r_mc;
  logic             r_sync;
  logic             r_poc;

  timing_prescaler #(
    .PHASE_LEN(PHASE_LEN)
  ) u_pre (
    .i_clk        (sysclk),
    .i_rst_n      (poc_n),
    .o_phase_step (w_step)
  );

  always_comb begin
    w_ph_n   = r_ph;
    w_sub_n  = r_sub;
    w_wrap   = 1'b0;
    if (w_step) begin
      w_ph_n = ph_e'(r_ph + 2'd1);
      if (r_ph == PH_GAP2) begin
        w_sub_n = sub_e'(r_sub + 3'd1);
        w_wrap  = (r_sub == SUB_X3);
      end
    end
    // The X3->A1 step leaving reset is not a completed cycle.
    w_pcnt_n = r_pcnt;
    if (w_wrap && r_armed && (r_pcnt != POC_MAX)) begin
      w_pcnt_n = r_pcnt + PCW'(1);
    end
    w_armed_n = r_armed | (w_ph_n == PH_CLK2);
  end

  always_comb begin
    w_clk1 = (w_ph_n == PH_CLK1);
    w_clk2 = (w_ph_n == PH_CLK2);
    // P0/P1 still carry the previous subcycle's strobe.
    w_idx  = w_ph_n[1] ? 3'(w_sub_n)
                       : 3'(w_sub_n) - 3'd1;
    w_stb  = '0;
    if (w_ph_n[1] || r_armed) begin
      w_stb = STB_W'(1) << w_idx;
    end
    w_m11  = (w_sub_n == SUB_M1);
    w_mc   = w_stb[STB_M12] | w_stb[STB_M22]
           | (w_clk1 & ~(w_m11 | w_stb[STB_M12]));
    w_sync = (w_sub_n == SUB_X3);
    w_poc  = (w_pcnt_n != POC_MAX);
  end

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      r_sub   <= SUB_X3;
      r_ph    <= PH_GAP2;
      r_pcnt  <= '0;
      r_armed <= 1'b0;
      r_clk1  <= 1'b0;
      r_clk2  <= 1'b0;
      r_stb   <= '0;
      r_mc    <= 1'b0;
      r_sync  <= 1'b0;
      r_poc   <= 1'b1;
    end else begin
      r_sub   <= w_sub_n;
      r_ph    <= w_ph_n;
      r_pcnt  <= w_pcnt_n;
      r_armed <= w_armed_n;
      r_clk1  <= w_clk1;
      r_clk2  <= w_clk2;
      r_stb   <= w_stb;
      r_mc    <= w_mc;
      r_sync  <= w_sync;
      r_poc   <= w_poc;
    end
  end

  assign o_tg.clk1 = r_clk1;
  assign o_tg.clk2 = r_clk2;
  assign o_tg.a12  = r_stb[STB_A12];
  assign o_tg.a22  = r_stb[STB_A22];
  assign o_tg.a32  = r_stb[STB_A32];
  assign o_tg.m12  = r_stb[STB_M12];
  assign o_tg.m22  = r_stb[STB_M22];
  assign o_tg.x12  = r_stb[STB_X12];
  assign o_tg.x22  = r_stb[STB_X22];
  assign o_tg.x32  = r_stb[STB_X32];
  assign o_tg.m12_m22_clk1_m11_m12 = r_mc;
  assign o_tg.sync = r_sync;
  assign o_tg.poc  = r_poc;

endmodule

// File: tb/tb_timing_gen.sv
// Self-checking bench for timing_gen with PHASE_LEN=2, POC_CYCLES=2.
// Vector table plus cycle model; reset, free run and mid-cycle reset.
module tb_timing_gen;

  logic sysclk = 1'b0;
  logic poc_n  = 1'b0;

  timing_gen_if tg ();

  timing_gen #(
    .PHASE_LEN (2),
    .POC_CYCLES(2)
  ) dut (
    .sysclk (sysclk),
    .poc_n  (poc_n),
    .o_tg   (tg.master)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int          cyc;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;
  int   k      = 0;
  int   ti     = 0;

  function automatic logic [7:0] act_stb();
    return {tg.x32, tg.x22, tg.x12, tg.m22,
            tg.m12, tg.a32, tg.a22, tg.a12};
  endfunction

  function automatic logic [12:0] act_v();
    return {tg.clk1, tg.clk2, act_stb(),
            tg.m12_m22_clk1_m11_m12, tg.sync, tg.poc};
  endfunction

  // kk = edges since reset release (1 = A1 P0 first tick).
  function automatic logic [12:0] model(int kk);
    int p, s, ph, idx;
    logic c1, c2, mc, sy, pc;
    logic [7:0] stb;
    p   = (kk - 1) % 64;
    s   = p / 8;
    ph  = (p % 8) / 2;
    c1  = (ph == 0);
    c2  = (ph == 2);
    stb = '0;
    if (ph >= 2) idx = s;
    else if (kk <= 4) idx = -1;
    else idx = (s + 7) % 8;
    if (idx >= 0) stb[idx] = 1'b1;
    mc = stb[3] | stb[4] | (c1 & (s != 3) & ~stb[3]);
    sy = (s == 7);
    pc = (kk <= 128);
    return {c1, c2, stb, mc, sy, pc};
  endfunction

  function automatic vec_t mk(int c, logic c1, logic c2,
                              logic [7:0] s, logic m,
                              logic y, logic p);
    vec_t v;
    v.cyc = c;
    v.exp = {c1, c2, s, m, y, p};
    return v;
  endfunction

  task automatic chk(string nm, logic [12:0] a, logic [12:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s k=%0d got %b want %b", nm, k, a, e);
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      step();
      k++;
      chk("model", act_v(), model(k));
      if (k >= 5) begin
        total++;
        if ($countones(act_stb()) == 1) passed++;
        else $display("FAIL onehot k=%0d got %b want one bit", k, act_stb());
      end
      if (ti < tbl.size() && tbl[ti].cyc == k) begin
        chk("vec", act_v(), tbl[ti].exp);
        ti++;
      end
    end
  endtask

  initial begin
    tbl.push_back(mk(1,   1, 0, 8'h00, 1, 0, 1));
    tbl.push_back(mk(3,   0, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(5,   0, 1, 8'h01, 0, 0, 1));
    tbl.push_back(mk(9,   1, 0, 8'h01, 1, 0, 1));
    tbl.push_back(mk(13,  0, 1, 8'h02, 0, 0, 1));
    tbl.push_back(mk(25,  1, 0, 8'h04, 0, 0, 1));
    tbl.push_back(mk(29,  0, 1, 8'h08, 1, 0, 1));
    tbl.push_back(mk(33,  1, 0, 8'h08, 1, 0, 1));
    tbl.push_back(mk(37,  0, 1, 8'h10, 1, 0, 1));
    tbl.push_back(mk(41,  1, 0, 8'h10, 1, 0, 1));
    tbl.push_back(mk(45,  0, 1, 8'h20, 0, 0, 1));
    tbl.push_back(mk(49,  1, 0, 8'h20, 1, 0, 1));
    tbl.push_back(mk(57,  1, 0, 8'h40, 1, 1, 1));
    tbl.push_back(mk(61,  0, 1, 8'h80, 0, 1, 1));
    tbl.push_back(mk(65,  1, 0, 8'h80, 1, 0, 1));
    tbl.push_back(mk(69,  0, 1, 8'h01, 0, 0, 1));
    tbl.push_back(mk(128, 0, 0, 8'h80, 0, 1, 1));
    tbl.push_back(mk(129, 1, 0, 8'h80, 1, 0, 0));
    tbl.push_back(mk(130, 1, 0, 8'h80, 1, 0, 0));
    tbl.push_back(mk(193, 1, 0, 8'h80, 1, 0, 0));

    poc_n = 1'b0;
    repeat (5) step();
    chk("reset", act_v(), 13'b0_0_00000000_0_0_1);

    poc_n = 1'b1;
    k  = 0;
    ti = 0;
    run(64 * 13);
    run(37);

    poc_n = 1'b0;
    step();
    chk("midrst", act_v(), 13'b0_0_00000000_0_0_1);

    poc_n = 1'b1;
    k  = 0;
    ti = 0;
    run(200);
    chk("tbl_done", 13'(ti), 13'(tbl.size()));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
